// File: rtl/iforest_pkg.sv
// ============================================================================
// Module  : iforest_pkg
// Brief   : Shared types and defaults for the isolation-forest status path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package iforest_pkg;

  localparam int WINDOW_DEFAULT    = 16;
  localparam int ALARM_ON_DEFAULT  = 4;
  localparam int ALARM_OFF_DEFAULT = 2;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_t;

  typedef enum logic [0:0] {
    QUIET = 1'b0,
    ALARM = 1'b1
  } alarm_state_t;

endpackage

`default_nettype wire

// File: rtl/anomaly_flag_window.sv
// ============================================================================
// Module  : anomaly_flag_window
// Brief   : WINDOW-deep flag history with shift enable and fill tracking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module anomaly_flag_window #(
  parameter int WINDOW = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic shift,
  input  logic flag_in,
  output logic oldest_flag,
  output logic full
);

  localparam int FILL_W = $clog2(WINDOW) + 1;

  logic [WINDOW-1:0] r_hist;
  logic [FILL_W-1:0] r_fill;

  // Newest flag enters at bit 0; bit WINDOW-1 is the one about to leave.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift) begin
      r_hist <= {r_hist[WINDOW-2:0], flag_in};
      if (r_fill != FILL_W'(WINDOW)) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  assign oldest_flag = r_hist[WINDOW-1];
  assign full        = (r_fill == FILL_W'(WINDOW));

endmodule

`default_nettype wire

// File: rtl/anomaly_window_monitor.sv
// ============================================================================
// Module  : anomaly_window_monitor
// Brief   : Sliding-window anomaly count, hysteretic alarm and periodic report.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module anomaly_window_monitor
  import iforest_pkg::*;
#(
  parameter int WINDOW    = WINDOW_DEFAULT,
  parameter int CNT_W     = $clog2(WINDOW) + 1,
  parameter int ALARM_ON  = ALARM_ON_DEFAULT,
  parameter int ALARM_OFF = ALARM_OFF_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_done,
  input  logic             anomaly_flag,
  input  logic             clear,
  output logic [CNT_W-1:0] anomaly_count,
  output logic             window_full,
  output logic             alarm,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [CNT_W-1:0] report_count,
  output logic             report_overrun
);

  localparam int IDX_W = $clog2(WINDOW);

  logic             w_oldest;
  logic             w_hist_full;
  logic [CNT_W-1:0] w_count_next;
  logic             w_boundary;
  logic [IDX_W-1:0] r_idx;

  fill_state_t      r_fill_state;
  fill_state_t      w_fill_next;
  alarm_state_t     r_alarm_state;
  alarm_state_t     w_alarm_next;

  anomaly_flag_window #(
    .WINDOW (WINDOW)
  ) u_window (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .shift       (sample_done),
    .flag_in     (anomaly_flag),
    .oldest_flag (w_oldest),
    .full        (w_hist_full)
  );

  // History is zero-filled, so gating with full only matters for clarity.
  assign w_count_next = anomaly_count + CNT_W'(anomaly_flag)
                      - CNT_W'(w_hist_full & w_oldest);
  assign w_boundary   = sample_done && (r_idx == IDX_W'(WINDOW - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anomaly_count <= '0;
      r_idx         <= '0;
    end else if (clear) begin
      anomaly_count <= '0;
      r_idx         <= '0;
    end else if (sample_done) begin
      anomaly_count <= w_count_next;
      r_idx         <= r_idx + 1'b1;
    end
  end

  // Fill FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_fill_state <= FILL;
    else        r_fill_state <= w_fill_next;
  end

  always_comb begin
    w_fill_next = r_fill_state;
    if (clear) begin
      w_fill_next = FILL;
    end else begin
      case (r_fill_state)
        FILL:    if (w_boundary) w_fill_next = RUN;
        RUN:     w_fill_next = RUN;
        default: w_fill_next = FILL;
      endcase
    end
  end

  always_comb begin
    window_full = (r_fill_state == RUN);
  end

  // Alarm FSM, judged on the count this sample produces
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_alarm_state <= QUIET;
    else        r_alarm_state <= w_alarm_next;
  end

  always_comb begin
    w_alarm_next = r_alarm_state;
    if (clear) begin
      w_alarm_next = QUIET;
    end else if (sample_done) begin
      case (r_alarm_state)
        QUIET:   if (w_count_next >= CNT_W'(ALARM_ON))  w_alarm_next = ALARM;
        ALARM:   if (w_count_next <= CNT_W'(ALARM_OFF)) w_alarm_next = QUIET;
        default: w_alarm_next = QUIET;
      endcase
    end
  end

  always_comb begin
    alarm = (r_alarm_state == ALARM);
  end

  // A fresh report wins over acceptance; overrun only if the old one was unread.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      report_valid   <= 1'b0;
      report_count   <= '0;
      report_overrun <= 1'b0;
    end else if (clear) begin
      report_valid   <= 1'b0;
      report_count   <= '0;
      report_overrun <= 1'b0;
    end else if (w_boundary) begin
      report_count <= w_count_next;
      report_valid <= 1'b1;
      if (report_valid && !report_ready) begin
        report_overrun <= 1'b1;
      end
    end else if (report_valid && report_ready) begin
      report_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_anomaly_window_monitor.sv
// ============================================================================
// Module  : tb_anomaly_window_monitor
// Brief   : Directed bench with a sum-based reference model and scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anomaly_window_monitor;

  localparam int W   = 16;
  localparam int CW  = 5;
  localparam int ON  = 4;
  localparam int OFF = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sample_done = 1'b0;
  logic          anomaly_flag = 1'b0;
  logic          clear = 1'b0;
  logic          report_ready = 1'b0;
  logic [CW-1:0] anomaly_count;
  logic          window_full;
  logic          alarm;
  logic          report_valid;
  logic [CW-1:0] report_count;
  logic          report_overrun;

  anomaly_window_monitor #(
    .WINDOW    (W),
    .CNT_W     (CW),
    .ALARM_ON  (ON),
    .ALARM_OFF (OFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_done    (sample_done),
    .anomaly_flag   (anomaly_flag),
    .clear          (clear),
    .anomaly_count  (anomaly_count),
    .window_full    (window_full),
    .alarm          (alarm),
    .report_valid   (report_valid),
    .report_ready   (report_ready),
    .report_count   (report_count),
    .report_overrun (report_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit full;
    bit alarm;
    bit rv;
    int rc;
    bit ov;
  } exp_t;

  exp_t sb[$];

  bit m_hist[W];
  int m_seen, m_idx, m_cnt, m_rc;
  bit m_alarm, m_rv, m_ov;

  int total = 0;
  int bad   = 0;

  function automatic void model_reset();
    for (int i = 0; i < W; i++) m_hist[i] = 1'b0;
    m_seen  = 0;
    m_idx   = 0;
    m_cnt   = 0;
    m_rc    = 0;
    m_alarm = 1'b0;
    m_rv    = 1'b0;
    m_ov    = 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"},   32'(anomaly_count),  0);
    check({tag, "_full"},    32'(window_full),    0);
    check({tag, "_alarm"},   32'(alarm),          0);
    check({tag, "_rvalid"},  32'(report_valid),   0);
    check({tag, "_rcount"},  32'(report_count),   0);
    check({tag, "_overrun"}, 32'(report_overrun), 0);
  endtask

  // Count is recomputed as a plain sum over the history, independent of the
  // incremental add/subtract the design performs.
  task automatic step(input bit sd, input bit f, input bit clr, input bit rdy);
    exp_t e;
    bit   acc;
    bit   bnd;
    @(negedge clk);
    sample_done  = sd;
    anomaly_flag = f;
    clear        = clr;
    report_ready = rdy;
    if (clr) begin
      model_reset();
    end else begin
      acc = m_rv && rdy;
      if (sd) begin
        for (int i = W - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = f;
        if (m_seen < W) m_seen++;
        m_cnt = 0;
        for (int i = 0; i < W; i++) m_cnt += int'(m_hist[i]);
        if (!m_alarm && m_cnt >= ON)      m_alarm = 1'b1;
        else if (m_alarm && m_cnt <= OFF) m_alarm = 1'b0;
        bnd   = (m_idx == W - 1);
        m_idx = (m_idx + 1) % W;
        if (bnd) begin
          if (m_rv && !rdy) m_ov = 1'b1;
          m_rc = m_cnt;
          m_rv = 1'b1;
        end else if (acc) begin
          m_rv = 1'b0;
        end
      end else if (acc) begin
        m_rv = 1'b0;
      end
    end
    e.cnt   = m_cnt;
    e.full  = (m_seen >= W);
    e.alarm = m_alarm;
    e.rv    = m_rv;
    e.rc    = m_rc;
    e.ov    = m_ov;
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check("count",   32'(anomaly_count),  32'(e.cnt));
      check("full",    32'(window_full),    32'(e.full));
      check("alarm",   32'(alarm),          32'(e.alarm));
      check("rvalid",  32'(report_valid),   32'(e.rv));
      check("rcount",  32'(report_count),   32'(e.rc));
      check("overrun", 32'(report_overrun), 32'(e.ov));
    end
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Anomalies at samples 0..3, alarm rises on the fourth, report of 4
    for (int i = 0; i < W; i++) step(1'b1, (i < 4), 1'b0, 1'b0);
    // Flags without sample_done are ignored
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Ones drain out; second unread boundary sets overrun
    for (int i = 0; i < W; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Boundary coinciding with acceptance of a pending report
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < W - 1; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Clear together with a sample at count 5 discards the sample
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges mid-window
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    @(negedge clk);
    sample_done = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < W; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("final_count",  32'(anomaly_count), 32'(W));
    check("final_report", 32'(report_count),  32'(W));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
